// File: rtl/udma_eth_tx_frame_engine.sv
// Ethernet TX frame engine: queues frame descriptors, fetches each frame from L2 through
// the uDMA TX channel (word transfer + byte remainder) and streams it to the MAC as AXI-stream.
// Latency: descriptor pop to uDMA start pulse is 1 cycle; data beats pass combinationally uDMA -> stream.
// Backpressure: m_axis_tready_i stalls the uDMA data handshake directly; pad beats hold while stalled;
//               desc_ready_o drops when the descriptor queue is full.
// Ports: desc_* descriptor push, cfg_tx_* uDMA channel setup, data_tx_* uDMA data path,
//        m_axis_* MAC stream, busy/frame_done/err_zero_len/abort status, desc_count queue level.
module udma_eth_tx_frame_engine #(
    parameter int L2_AWIDTH_NOAL  = 12,
    parameter int TRANS_SIZE      = 16,
    parameter int DESC_DEPTH      = 4,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_CYCLES      = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          desc_valid_i,
    output logic                          desc_ready_o,
    input  logic [L2_AWIDTH_NOAL-1:0]     desc_addr_i,
    input  logic [TRANS_SIZE-1:0]         desc_size_i,
    input  logic                          clr_i,
    output logic [L2_AWIDTH_NOAL-1:0]     cfg_tx_startaddr_o,
    output logic [TRANS_SIZE-1:0]         cfg_tx_size_o,
    output logic [1:0]                    cfg_tx_datasize_o,
    output logic                          cfg_tx_en_o,
    output logic                          cfg_tx_clr_o,
    output logic                          data_tx_req_o,
    input  logic                          data_tx_gnt_i,
    output logic [1:0]                    data_tx_datasize_o,
    input  logic [31:0]                   data_tx_i,
    input  logic                          data_tx_valid_i,
    output logic                          data_tx_ready_o,
    output logic [31:0]                   m_axis_tdata_o,
    output logic [3:0]                    m_axis_tkeep_o,
    output logic                          m_axis_tvalid_o,
    output logic                          m_axis_tuser_o,
    output logic                          m_axis_tlast_o,
    input  logic                          m_axis_tready_i,
    output logic                          busy_o,
    output logic                          frame_done_o,
    output logic                          err_zero_len_o,
    output logic                          abort_o,
    output logic [$clog2(DESC_DEPTH):0]   desc_count_o
);

    localparam int PW = $clog2(DESC_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(IFG_CYCLES + 1) + 1;
    localparam logic [TRANS_SIZE:0] LP_MIN = (TRANS_SIZE + 1)'(MIN_FRAME_BYTES);
    localparam logic [TRANS_SIZE:0] LP_FOUR = (TRANS_SIZE + 1)'(4);

    typedef enum logic [2:0] {S_IDLE, S_REQ_W, S_XFER_W, S_REQ_B, S_XFER_B, S_PAD, S_GAP} state_t;

    state_t                    r_state;
    logic [L2_AWIDTH_NOAL-1:0] r_fifo_addr [DESC_DEPTH];
    logic [TRANS_SIZE-1:0]     r_fifo_size [DESC_DEPTH];
    logic [PW-1:0]             r_wptr, r_rptr;
    logic [CW-1:0]             r_count;
    logic [L2_AWIDTH_NOAL-1:0] r_cfg_addr, r_tail_addr;
    logic [TRANS_SIZE-1:0]     r_cfg_size, r_words_left;
    logic [1:0]                r_cfg_ds, r_rem;
    logic                      r_cfg_en, r_cfg_clr, r_done, r_err, r_abort, r_first;
    logic [TRANS_SIZE:0]       r_bytes_sent;
    logic [GW-1:0]             r_gap_cnt;

    logic                      w_push, w_pop, w_hs, w_tvalid, w_data_rdy, w_last_data, w_tlast;
    logic [31:0]               w_tdata;
    logic [3:0]                w_tkeep;
    logic [TRANS_SIZE:0]       w_beat_bytes, w_sent_next, w_pad_left;
    logic [L2_AWIDTH_NOAL-1:0] w_head_addr, w_tail_addr;
    logic [TRANS_SIZE-1:0]     w_head_size;

    // clr_i wins over both queue operations; it flushes the queue outright
    assign desc_ready_o = (r_count != CW'(DESC_DEPTH));
    assign w_push       = desc_valid_i & desc_ready_o & ~clr_i;
    assign w_pop        = (r_state == S_IDLE) & (r_count != '0) & ~clr_i;
    assign w_head_addr  = r_fifo_addr[r_rptr];
    assign w_head_size  = r_fifo_size[r_rptr];
    // Address of the byte remainder: start plus the word-aligned part of the length
    assign w_tail_addr  = w_head_addr + L2_AWIDTH_NOAL'({w_head_size[TRANS_SIZE-1:2], 2'b00});

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= desc_addr_i;
            r_fifo_size[r_wptr] <= desc_size_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clr_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Stream beat generation; the pad phase is marked as "last data" so tlast falls out of
    // the same byte-count test in every phase
    assign w_pad_left = LP_MIN - r_bytes_sent;

    always_comb begin
        w_tvalid     = 1'b0;
        w_tdata      = '0;
        w_tkeep      = '0;
        w_data_rdy   = 1'b0;
        w_beat_bytes = '0;
        w_last_data  = 1'b0;
        case (r_state)
            S_XFER_W: begin
                w_data_rdy   = m_axis_tready_i;
                w_tvalid     = data_tx_valid_i;
                w_tdata      = data_tx_i;
                w_tkeep      = 4'hF;
                w_beat_bytes = LP_FOUR;
                w_last_data  = (r_words_left == TRANS_SIZE'(1)) && (r_rem == 2'd0);
            end
            S_XFER_B: begin
                w_data_rdy   = m_axis_tready_i;
                w_tvalid     = data_tx_valid_i;
                w_tdata      = {24'h0, data_tx_i[7:0]};
                w_tkeep      = 4'h1;
                w_beat_bytes = (TRANS_SIZE + 1)'(1);
                w_last_data  = (r_rem == 2'd1);
            end
            S_PAD: begin
                w_tvalid    = 1'b1;
                w_last_data = 1'b1;
                if (w_pad_left >= LP_FOUR) begin
                    w_tkeep      = 4'hF;
                    w_beat_bytes = LP_FOUR;
                end else begin
                    w_tkeep      = (4'b0001 << w_pad_left[1:0]) - 4'b0001;
                    w_beat_bytes = w_pad_left;
                end
            end
            default: ;
        endcase
    end

    assign w_sent_next = r_bytes_sent + w_beat_bytes;
    assign w_tlast     = w_last_data & (w_sent_next >= LP_MIN);
    assign w_hs        = w_tvalid & m_axis_tready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_cfg_addr   <= '0;
            r_cfg_size   <= '0;
            r_cfg_ds     <= '0;
            r_cfg_en     <= 1'b0;
            r_cfg_clr    <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_abort      <= 1'b0;
            r_first      <= 1'b0;
            r_tail_addr  <= '0;
            r_words_left <= '0;
            r_rem        <= '0;
            r_bytes_sent <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_cfg_en  <= 1'b0;
            r_cfg_clr <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_abort   <= 1'b0;
            if (clr_i) begin
                r_cfg_clr <= 1'b1;
                r_abort   <= (r_state != S_IDLE) && (r_state != S_GAP);
                r_first   <= 1'b0;
                r_state   <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_pop) begin
                            r_bytes_sent <= '0;
                            r_first      <= 1'b1;
                            r_tail_addr  <= w_tail_addr;
                            r_rem        <= w_head_size[1:0];
                            r_words_left <= w_head_size >> 2;
                            r_cfg_addr   <= w_head_addr;
                            if (w_head_size == '0) begin
                                r_err <= 1'b1;
                            end else if (w_head_size[TRANS_SIZE-1:2] != '0) begin
                                r_cfg_size <= {w_head_size[TRANS_SIZE-1:2], 2'b00};
                                r_cfg_ds   <= 2'd2;
                                r_cfg_en   <= 1'b1;
                                r_state    <= S_REQ_W;
                            end else begin
                                r_cfg_size <= w_head_size;
                                r_cfg_ds   <= 2'd0;
                                r_cfg_en   <= 1'b1;
                                r_state    <= S_REQ_B;
                            end
                        end
                    end
                    S_REQ_W: if (data_tx_gnt_i) r_state <= S_XFER_W;
                    S_REQ_B: if (data_tx_gnt_i) r_state <= S_XFER_B;
                    S_XFER_W, S_XFER_B, S_PAD: begin
                        if (w_hs) begin
                            r_first      <= 1'b0;
                            r_bytes_sent <= w_sent_next;
                            if (r_state == S_XFER_W) r_words_left <= r_words_left - 1'b1;
                            if (r_state == S_XFER_B) r_rem <= r_rem - 1'b1;
                            if (w_tlast) begin
                                r_done    <= 1'b1;
                                r_gap_cnt <= '0;
                                r_state   <= (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
                            end else if ((r_state == S_XFER_W) && (r_words_left == TRANS_SIZE'(1))
                                         && (r_rem != 2'd0)) begin
                                r_cfg_addr <= r_tail_addr;
                                r_cfg_size <= {{(TRANS_SIZE-2){1'b0}}, r_rem};
                                r_cfg_ds   <= 2'd0;
                                r_cfg_en   <= 1'b1;
                                r_state    <= S_REQ_B;
                            end else if (w_last_data) begin
                                r_state <= S_PAD;
                            end
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt == GW'(IFG_CYCLES - 1)) r_state <= S_IDLE;
                        else                                  r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cfg_tx_startaddr_o = r_cfg_addr;
    assign cfg_tx_size_o      = r_cfg_size;
    assign cfg_tx_datasize_o  = r_cfg_ds;
    assign data_tx_datasize_o = r_cfg_ds;
    assign cfg_tx_en_o        = r_cfg_en;
    assign cfg_tx_clr_o       = r_cfg_clr;
    assign data_tx_req_o      = (r_state == S_REQ_W) || (r_state == S_REQ_B);
    assign data_tx_ready_o    = w_data_rdy;
    assign m_axis_tdata_o     = w_tdata;
    assign m_axis_tkeep_o     = w_tkeep;
    assign m_axis_tvalid_o    = w_tvalid;
    assign m_axis_tuser_o     = r_first & w_tvalid;
    assign m_axis_tlast_o     = w_tlast;
    assign busy_o             = (r_state != S_IDLE);
    assign frame_done_o       = r_done;
    assign err_zero_len_o     = r_err;
    assign abort_o            = r_abort;
    assign desc_count_o       = r_count;

endmodule

// File: tb/tb_udma_eth_tx_frame_engine.sv
// Testbench for udma_eth_tx_frame_engine: uDMA memory model plus beat/transfer scoreboards.
// Latency: expectations are queued at descriptor push and compared when the DUT produces them.
// Backpressure: MAC tready is randomised, forced low, or forced high per test phase.
module tb_udma_eth_tx_frame_engine;

    localparam int AW = 12, TS = 16, DD = 4, MIN = 60, IFG = 3;

    logic            clk_i = 1'b0, rst_i = 1'b1;
    logic            desc_valid_i = 0, clr_i = 0, data_tx_gnt_i = 0, data_tx_valid_i = 0, m_axis_tready_i = 0;
    logic [AW-1:0]   desc_addr_i = '0;
    logic [TS-1:0]   desc_size_i = '0;
    logic [31:0]     data_tx_i = '0;
    logic            desc_ready_o, cfg_tx_en_o, cfg_tx_clr_o, data_tx_req_o, data_tx_ready_o;
    logic [AW-1:0]   cfg_tx_startaddr_o;
    logic [TS-1:0]   cfg_tx_size_o;
    logic [1:0]      cfg_tx_datasize_o, data_tx_datasize_o;
    logic [31:0]     m_axis_tdata_o;
    logic [3:0]      m_axis_tkeep_o;
    logic            m_axis_tvalid_o, m_axis_tuser_o, m_axis_tlast_o;
    logic            busy_o, frame_done_o, err_zero_len_o, abort_o;
    logic [2:0]      desc_count_o;

    udma_eth_tx_frame_engine #(
        .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .DESC_DEPTH(DD), .MIN_FRAME_BYTES(MIN), .IFG_CYCLES(IFG)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_addr_i(desc_addr_i), .desc_size_i(desc_size_i), .clr_i(clr_i),
        .cfg_tx_startaddr_o(cfg_tx_startaddr_o), .cfg_tx_size_o(cfg_tx_size_o),
        .cfg_tx_datasize_o(cfg_tx_datasize_o), .cfg_tx_en_o(cfg_tx_en_o), .cfg_tx_clr_o(cfg_tx_clr_o),
        .data_tx_req_o(data_tx_req_o), .data_tx_gnt_i(data_tx_gnt_i),
        .data_tx_datasize_o(data_tx_datasize_o), .data_tx_i(data_tx_i),
        .data_tx_valid_i(data_tx_valid_i), .data_tx_ready_o(data_tx_ready_o),
        .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tkeep_o(m_axis_tkeep_o),
        .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tuser_o(m_axis_tuser_o),
        .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tready_i(m_axis_tready_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_zero_len_o(err_zero_len_o),
        .abort_o(abort_o), .desc_count_o(desc_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {logic [31:0] dat; logic [3:0] keep; logic user; logic last;} beat_t;
    typedef struct packed {logic [AW-1:0] addr; logic [TS-1:0] size; logic [1:0] ds;} xfer_t;

    beat_t sb_q[$];
    xfer_t xf_q[$];
    int    n_tests = 0, n_fail = 0;

    // uDMA model and monitor state
    logic [AW-1:0] m_addr = '0;
    int            m_left = 0;
    logic [1:0]    m_ds = '0;
    logic          m_vld = 1'b0;
    bit            prev_udma_hs = 0, prev_tlast = 0, prev_clr = 0, clr_mid = 0, clr_req = 0, gap_on = 0;
    int            gap_n = 0, frame_beats = 0, err_seen = 0, exp_err = 0, tready_mode = 0;
    bit            push_pend = 0;
    logic [AW-1:0] push_addr = '0;
    logic [TS-1:0] push_size = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_b(input logic [AW-1:0] a);
        logic [15:0] t;
        t = {4'b0, a} * 16'd13 + 16'd7;
        return t[7:0];
    endfunction

    function automatic logic [31:0] mem_w(input logic [AW-1:0] a);
        return {mem_b(AW'(a + 3)), mem_b(AW'(a + 2)), mem_b(AW'(a + 1)), mem_b(a)};
    endfunction

    function automatic logic [31:0] keep_mask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    // Builds the expected uDMA transfers and stream beats of one frame
    task automatic expect_frame(input logic [AW-1:0] addr, input int size);
        int    words, rem, sent, left;
        beat_t b;
        beat_t fb[$];
        xfer_t x;
        words = size / 4;
        rem   = size % 4;
        sent  = 0;
        if (size == 0) begin
            exp_err++;
            return;
        end
        if (words > 0) begin
            x.addr = addr; x.size = TS'(words * 4); x.ds = 2'd2;
            xf_q.push_back(x);
        end
        if (rem > 0) begin
            x.addr = AW'(addr + words * 4); x.size = TS'(rem); x.ds = 2'd0;
            xf_q.push_back(x);
        end
        for (int w = 0; w < words; w++) begin
            b.dat = mem_w(AW'(addr + 4 * w)); b.keep = 4'hF; b.user = (fb.size() == 0); b.last = 0;
            fb.push_back(b);
            sent += 4;
        end
        for (int r = 0; r < rem; r++) begin
            b.dat = {24'h0, mem_b(AW'(addr + 4 * words + r))}; b.keep = 4'h1; b.user = (fb.size() == 0); b.last = 0;
            fb.push_back(b);
            sent += 1;
        end
        while (sent < MIN) begin
            left = MIN - sent;
            b.dat = 32'h0; b.user = 0; b.last = 0;
            if (left >= 4) begin b.keep = 4'hF; sent += 4; end
            else begin b.keep = 4'((1 << left) - 1); sent += left; end
            fb.push_back(b);
        end
        b = fb[fb.size() - 1];
        b.last = 1;
        fb[fb.size() - 1] = b;
        foreach (fb[i]) sb_q.push_back(fb[i]);
    endtask

    // One clock: drive inputs at the falling edge, then sample what the next rising edge will see
    task automatic cycle();
        int    step;
        beat_t e;
        xfer_t x;
        @(negedge clk_i);
        if (prev_udma_hs) begin
            step = (m_ds == 2'd2) ? 4 : 1;
            m_addr = AW'(m_addr + step);
            m_left -= step;
            m_vld = 0;
        end
        desc_valid_i = push_pend;
        desc_addr_i  = push_addr;
        desc_size_i  = push_size;
        clr_i        = clr_req;
        if (clr_req) begin m_left = 0; m_vld = 0; end
        m_axis_tready_i = clr_req ? 1'b0 : (tready_mode == 1) ? 1'b0 : (tready_mode == 2) ? 1'b1 : ($urandom % 4 != 0);
        data_tx_gnt_i   = data_tx_req_o && ($urandom % 2 == 1);
        if (!m_vld && m_left > 0 && ($urandom % 4 != 0)) m_vld = 1;
        data_tx_valid_i = m_vld;
        data_tx_i       = (m_ds == 2'd2) ? mem_w(m_addr) : {16'hDEAD, 8'hBE, mem_b(m_addr)};
        #1;
        prev_udma_hs = data_tx_valid_i && data_tx_ready_o;
        if (push_pend && desc_ready_o && !clr_req) begin
            expect_frame(push_addr, int'(push_size));
            push_pend = 0;
        end
        if (prev_clr) begin
            check("clr_pulse", cfg_tx_clr_o, 1);
            check("abort_pulse", abort_o, clr_mid);
            check("clr_busy", busy_o, 0);
            check("clr_count", desc_count_o, 0);
        end else begin
            if (cfg_tx_clr_o) check("clr_unexp", cfg_tx_clr_o, 0);
            if (abort_o) check("abort_unexp", abort_o, 0);
        end
        if (frame_done_o || prev_tlast) check("frame_done", frame_done_o, prev_tlast);
        if (err_zero_len_o) err_seen++;
        if (gap_on) begin
            if (busy_o && gap_n < 20) gap_n++;
            else begin
                check("ifg_cycles", gap_n, IFG);
                gap_on = 0;
            end
        end
        if (cfg_tx_en_o) begin
            if (xf_q.size() == 0) check("udma_unexp", 1, 0);
            else begin
                x = xf_q.pop_front();
                check("udma_addr", cfg_tx_startaddr_o, x.addr);
                check("udma_size", cfg_tx_size_o, x.size);
                check("udma_ds", cfg_tx_datasize_o, x.ds);
                check("udma_ds_mirror", data_tx_datasize_o, x.ds);
            end
            m_addr = cfg_tx_startaddr_o;
            m_left = int'(cfg_tx_size_o);
            m_ds   = cfg_tx_datasize_o;
            m_vld  = 0;
        end
        prev_tlast = 0;
        if (m_axis_tvalid_o && m_axis_tready_i) begin
            if (sb_q.size() == 0) check("beat_unexp", 1, 0);
            else begin
                e = sb_q.pop_front();
                check("beat_keep", m_axis_tkeep_o, e.keep);
                check("beat_data", m_axis_tdata_o & keep_mask(e.keep), e.dat & keep_mask(e.keep));
                check("beat_user_last", {m_axis_tuser_o, m_axis_tlast_o}, {e.user, e.last});
            end
            frame_beats++;
            if (m_axis_tlast_o) begin
                prev_tlast = 1; gap_on = 1; gap_n = 0; frame_beats = 0;
            end
        end
        prev_clr = clr_req;
        clr_req  = 0;
    endtask

    task automatic push(input logic [AW-1:0] a, input int s);
        int n;
        push_addr = a; push_size = TS'(s); push_pend = 1;
        n = 0;
        while (push_pend && n < 300) begin cycle(); n++; end
        if (push_pend) begin check("push_timeout", 0, 1); push_pend = 0; end
    endtask

    task automatic drain();
        int  n;
        bit  done;
        n = 0; done = 0;
        while (!done && n < 4000) begin
            cycle();
            n++;
            done = (sb_q.size() == 0) && (xf_q.size() == 0) && !busy_o && (desc_count_o == 0) && !gap_on;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    logic [31:0] snap_dat;
    int          n_wait;

    initial begin
        // Reset values while reset is held
        repeat (2) @(negedge clk_i);
        check("rst_desc_ready", desc_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_tvalid", m_axis_tvalid_o, 0);
        check("rst_cfg_en", cfg_tx_en_o, 0);
        check("rst_req", data_tx_req_o, 0);
        check("rst_count", desc_count_o, 0);
        check("rst_pulses", {frame_done_o, err_zero_len_o, abort_o, cfg_tx_clr_o}, 0);
        rst_i = 1'b0;

        // Aligned 64-byte frame, remainder frame, short padded frame
        push(12'h100, 64); drain();
        push(12'h200, 67); drain();
        push(12'h300, 10); drain();
        // Zero-length descriptor is dropped, next one proceeds
        push(12'h400, 0); push(12'h500, 64); drain();
        check("zero_len_pulses", err_seen, exp_err);

        // Queue full under MAC stall
        tready_mode = 1;
        push(12'h600, 64); push(12'h700, 67); push(12'h800, 10); push(12'h900, 3); push(12'hA00, 8);
        repeat (20) cycle();
        snap_dat = m_axis_tdata_o;
        repeat (10) cycle();
        check("stall_tvalid", m_axis_tvalid_o, 1);
        check("stall_tdata", m_axis_tdata_o, snap_dat);
        check("full_count", desc_count_o, 4);
        check("full_ready", desc_ready_o, 0);
        push_addr = 12'hB00; push_size = 16'd4; push_pend = 1;
        cycle();
        push_pend = 0;
        cycle();
        check("full_push_ignored", desc_count_o, 4);
        tready_mode = 0;
        drain();

        // Abort mid-frame with two descriptors queued
        push(12'hC00, 64); push(12'hD00, 64); push(12'hE00, 64);
        n_wait = 0;
        while (frame_beats < 5 && n_wait < 500) begin cycle(); n_wait++; end
        check("abort_reach_beat5", frame_beats, 5);
        check("abort_queued", desc_count_o, 2);
        clr_mid = 1; clr_req = 1;
        cycle();
        cycle();
        sb_q.delete(); xf_q.delete();
        frame_beats = 0; clr_mid = 0;
        repeat (5) cycle();
        check("post_abort_idle", {busy_o, m_axis_tvalid_o, cfg_tx_en_o}, 0);

        // Recovery after abort
        tready_mode = 2;
        push(12'hF00, 8); drain();
        check("zero_len_total", err_seen, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/udma_eth_tx_frame_engine.md
Name: udma_eth_tx_frame_engine

Overview:
Parametrised Ethernet TX controller between the uDMA TX channel and the MAC AXI-stream input. It accepts frame descriptors (L2 address and byte length) into a queue and fetches each frame as a word-sized uDMA transfer followed by a byte-sized remainder transfer. It emits AXI-stream beats with byte-enable keep, first-beat tuser and last-beat tlast. It also zero-pads short frames to a minimum length and enforces an inter-frame gap.

Parameters:
L2_AWIDTH_NOAL, 12, L2 byte address width
TRANS_SIZE, 16, byte length width
DESC_DEPTH, 4, descriptor FIFO entries (power of 2, >=2)
MIN_FRAME_BYTES, 60, frames shorter than this are zero-padded; 0 disables padding
IFG_CYCLES, 3, idle cycles forced between tlast and next frame start

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
desc_valid_i  in  1  descriptor push request
desc_ready_o  out  1  FIFO not full
desc_addr_i  in  L2_AWIDTH_NOAL  frame start address
desc_size_i  in  TRANS_SIZE  frame length in bytes
clr_i  in  1  abort current frame and flush queue
cfg_tx_startaddr_o  out  L2_AWIDTH_NOAL  uDMA start address
cfg_tx_size_o  out  TRANS_SIZE  uDMA transfer size
cfg_tx_datasize_o  out  2  0=byte, 2=word
cfg_tx_en_o  out  1  one-cycle start pulse
cfg_tx_clr_o  out  1  one-cycle clear pulse
data_tx_req_o  out  1  channel request
data_tx_gnt_i  in  1  channel grant
data_tx_datasize_o  out  2  mirrors cfg_tx_datasize_o
data_tx_i  in  32  fetched data
data_tx_valid_i  in  1  data valid
data_tx_ready_o  out  1  data accepted
m_axis_tdata_o  out  32  stream data
m_axis_tkeep_o  out  4  byte enables, LSB-first contiguous
m_axis_tvalid_o  out  1  beat valid
m_axis_tuser_o  out  1  first beat of frame
m_axis_tlast_o  out  1  last beat of frame
m_axis_tready_i  in  1  MAC ready
busy_o  out  1  frame in progress or gap running
frame_done_o  out  1  one-cycle pulse on tlast handshake
err_zero_len_o  out  1  one-cycle pulse when a size-0 descriptor is dropped
abort_o  out  1  one-cycle pulse when clr_i truncates a frame
desc_count_o  out  $clog2(DESC_DEPTH)+1  queued descriptor count

Behaviour:
- Reset: every output 0 except desc_ready_o=1. FIFO empty, counters 0, state IDLE.
- Descriptor push on desc_valid_i&desc_ready_o. A simultaneous push and pop keeps desc_count_o constant. A push while full is ignored.
- States: IDLE, REQ_W, XFER_W, REQ_B, XFER_B, PAD, GAP.
- IDLE with FIFO non-empty: pop the descriptor.
  - size==0: pulse err_zero_len_o, stay in IDLE.
  - size>=4: load words_left=size>>2, rem=size[1:0], pulse cfg_tx_en_o, size={size[TS-1:2],2'b00}, datasize=2, go to REQ_W.
  - size<4: go to REQ_B directly with addr=desc_addr, rem=size.
- REQ_x: data_tx_req_o=1 until data_tx_gnt_i; on grant go to XFER_x.
- XFER_W: data_tx_ready_o=m_axis_tready_i; tvalid=data_tx_valid_i; keep=4'hF. Each handshake decrements words_left. After the last word:
  - rem!=0: pulse cfg_tx_en_o, addr=start+(words<<2), size=rem, datasize=0, go to REQ_B.
  - rem==0: go to PAD if padding is needed, else GAP.
- XFER_B: each byte is output in data[7:0] with keep=4'h1. After rem bytes, go to PAD or GAP.
- PAD needed iff bytes_sent<MIN_FRAME_BYTES. The engine emits zero beats with keep=4'hF; the final pad beat uses keep=(1<<(MIN-sent))-1 with the width clipped to 4 bits. Pad beats do not touch uDMA.
- tuser=1 on the first handshaked beat only. tlast=1 on the final beat, whichever phase that beat falls in.
- bytes_sent is a TRANS_SIZE+1-bit counter incremented by popcount(keep) per handshake.
- GAP: count IFG_CYCLES cycles, then return to IDLE. IFG_CYCLES=0 goes straight to IDLE.
- busy_o=(state!=IDLE).
- tvalid is never withdrawn before tready. In PAD, tdata and tkeep hold stable while stalled.
- clr_i, any state: pulse cfg_tx_clr_o and flush the FIFO. If mid-frame (XFER/REQ/PAD), pulse abort_o and emit no tlast. Next cycle the state is IDLE with no GAP. clr_i has priority over a same-cycle push.
- Reset asserted mid-frame: all outputs return to reset values asynchronously.

Test Plan:
1. Push {addr=0x100,size=64}, MIN=60 -> one word transfer (size 64, datasize 2), 16 beats keep=F, tuser on beat 0, tlast on beat 15, frame_done_o pulse, then 3 idle cycles.
2. Push {0x200,size=67} -> word transfer (64 bytes), then byte transfer at 0x240 size 3 with datasize 0; 16 word beats + 3 byte beats keep=1; tlast on the third byte.
3. Push size=10, MIN=60 -> 2 words + 2 bytes from uDMA, then 12 zero pad beats keep=F and a final pad beat keep=3 (60 bytes total), tlast on that beat.
4. Push size=0 then size=64 -> err_zero_len_o pulse, no uDMA activity for it, second frame sent normally.
5. Fill 4 descriptors, hold tready=0 for 20 cycles -> desc_ready_o=0, desc_count_o=4, tvalid/tdata stable; release -> four frames each separated by >=3 idle cycles.
6. clr_i during word 5 of a 64-byte frame with 2 queued -> cfg_tx_clr_o and abort_o pulse, no tlast, desc_count_o=0, busy_o=0 next cycle.
